register_file_mp: RTL
=====================

REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-003 SHALL have parameter REG_COUNT, default 32, number of architectural registers, at most 2**ADDR_WIDTH.
REQ-004 SHALL have parameter NUM_RD, default 3, number of read ports, range 1..8.
REQ-005 SHALL have parameter BYPASS, default 1: 1 = write-through reads, 0 = reads return stored value.
REQ-006 SHALL have CLK, input, 1, sole clock; all state updates on its rising edge.
REQ-007 SHALL have RST_N, input, 1, asynchronous active-low reset.
REQ-008 SHALL have CLR_REQ, input, 1, synchronous request to re-zero all registers.
REQ-009 SHALL have WE0, A0, WD0, inputs, 1 / ADDR_WIDTH / DATA_WIDTH, write port 0.
REQ-010 SHALL have WE1, A1, WD1, inputs, 1 / ADDR_WIDTH / DATA_WIDTH, write port 1.
REQ-011 SHALL have RA, input, NUM_RD*ADDR_WIDTH, flattened read addresses; port i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-012 SHALL have RD, output, NUM_RD*DATA_WIDTH, flattened combinational read data; port i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-013 SHALL have READY, output, 1, high when the array is cleared and accepting writes.

Function
REQ-014 SHALL implement states CLEAR and RUN only.
REQ-015 In CLEAR, SHALL write zero to register CNT each cycle, CNT running 1..REG_COUNT-1, then enter RUN on the next edge; the sweep takes REG_COUNT-1 cycles.
REQ-016 In RUN, CLR_REQ=1 SHALL move to CLEAR with CNT=1 on the next edge; port writes in that cycle are discarded.
REQ-017 In CLEAR, SHALL ignore CLR_REQ, WE0 and WE1.
REQ-018 In CLEAR, SHALL drive READY=0 and all RD slices to 0.
REQ-019 In RUN, SHALL drive READY=1.
REQ-020 In RUN, WEn=1 with An!=0 and An<REG_COUNT SHALL store WDn at the edge.
REQ-021 Writes to address 0 or to addresses >=REG_COUNT SHALL be dropped.
REQ-022 When both ports write the same valid address in one cycle, port 1 data SHALL be stored.
REQ-023 Read port i SHALL return 0 when its address is 0 or >=REG_COUNT.
REQ-024 With BYPASS=1 in RUN, a read matching an active valid write SHALL return that cycle's write data, port 1 taking precedence over port 0; otherwise it SHALL return the stored value.
REQ-025 With BYPASS=0, a read SHALL return the stored value; new data SHALL appear the cycle after the write edge.
REQ-026 Read ports SHALL be independent; any port may read any address, including all ports reading one address.

Reset
REQ-027 RST_N=0 SHALL immediately force state CLEAR, CNT=1, READY=0 and all RD=0, regardless of CLK.
REQ-028 Storage array contents SHALL NOT be reset directly; zeroing happens only through the CLEAR sweep.
REQ-029 Reset asserted mid-sweep or mid-write SHALL restart the sweep from CNT=1 after release.
REQ-030 The first sweep step SHALL occur on the first rising CLK edge after RST_N rises.

Structure
REQ-031 State encoding (CLEAR=1'b0, RUN=1'b1) SHALL live in shared package/include register_file_pkg for reuse by the pipeline control.
REQ-032 The sweep counter and state register SHALL form one sub-module, regfile_clear_seq, with outputs clr_active, clr_addr and ready.
REQ-033 Read ports and bypass muxes SHALL be built with a generate loop over NUM_RD.

Verification
REQ-034 Reset release -> READY=0 for exactly 31 cycles, then 1; every read of x1..x31 returns 0.
REQ-035 In RUN, WE0 A0=5 WD0=0xDEADBEEF and WE1 A1=5 WD1=0x12345678 -> next cycle RA=5 reads 0x12345678; with BYPASS=1 the same cycle also reads 0x12345678.
REQ-036 Write A0=0 WD0=0xFFFFFFFF -> all read ports addressing x0 return 0 in the same and following cycles.
REQ-037 With BYPASS=0, write x7=0xA5A5A5A5 -> 0 (old value) in the write cycle, 0xA5A5A5A5 in the next cycle on all 3 ports.
REQ-038 CLR_REQ together with a write of x3=0x55 -> write discarded, READY low for 31 cycles, x3 reads 0 afterwards.
REQ-039 RST_N pulsed low at sweep step 10 -> READY stays low for 31 full cycles after release.

Source files
------------

// File: rtl/register_file_pkg.sv
// Purpose : shared definitions for the multi-port register file and the pipeline control around it.
// Latency : n/a (types only).
// Backpress: n/a; no ports. CLEAR/RUN encoding is fixed so external control can decode the state bit directly.
package register_file_pkg;

    // Sequencer state. CLEAR sweeps zeros through the array; RUN accepts port writes.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// Purpose : zeroing sequencer for the register file; owns the CLEAR/RUN state and the sweep counter.
// Latency : sweep touches one register per cycle, x1..x(REG_COUNT-1), then enters RUN on the following edge.
// Backpress: ready is low for the whole sweep; clr_req is only honoured while in RUN.
//
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset (reset forces CLEAR, counter = 1)
//   clr_req     - request to re-run the sweep (RUN only)
//   clr_active  - high while sweeping; the array must write zero to clr_addr this cycle
//   clr_addr    - register being zeroed this cycle
//   ready       - high in RUN
module regfile_clear_seq
    import register_file_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req,
    output logic                  clr_active,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  ready
);

    localparam logic [ADDR_WIDTH-1:0] CNT_FIRST = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST  = ADDR_WIDTH'(REG_COUNT - 1);

    rf_state_e             state;
    rf_state_e             state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= CNT_FIRST;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLEAR: begin
                // x0 is hard-wired zero, so the sweep starts at 1. The counter is
                // parked back at 1 on exit so a later clear request starts clean.
                // '>=' keeps a degenerate REG_COUNT from sweeping forever.
                if (cnt >= CNT_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = CNT_FIRST;
                end else begin
                    cnt_nxt = cnt + CNT_FIRST;
                end
            end
            RUN: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = CNT_FIRST;
                end
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = CNT_FIRST;
            end
        endcase
    end

    // Decoded straight from the state flop so reset takes effect without a clock.
    assign clr_active = (state == CLEAR);
    assign ready      = (state == RUN);
    assign clr_addr   = cnt;

endmodule

// File: rtl/register_file_mp.sv
// Purpose : multi-read, dual-write register file with x0 hard-wired to zero and a self-clearing array.
// Latency : reads are combinational; with BYPASS=1 same-cycle write data is forwarded, else visible next cycle.
// Backpress: READY low during the clear sweep; writes and clear requests are ignored until READY returns.
//
// Ports:
//   CLK, RST_N      - clock and asynchronous active-low reset
//   CLR_REQ         - re-zero the whole array (accepted in RUN; same-cycle writes are discarded)
//   WE0/A0/WD0      - write port 0
//   WE1/A1/WD1      - write port 1 (wins over port 0 on an address collision)
//   RA              - NUM_RD read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   RD              - NUM_RD read data words, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   READY           - high when the array is cleared and accepting writes
module register_file_mp
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_COUNT  = 32,
    parameter int NUM_RD     = 3,
    parameter int BYPASS     = 1
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         CLR_REQ,
    input  logic                         WE0,
    input  logic [ADDR_WIDTH-1:0]        A0,
    input  logic [DATA_WIDTH-1:0]        WD0,
    input  logic                         WE1,
    input  logic [ADDR_WIDTH-1:0]        A1,
    input  logic [DATA_WIDTH-1:0]        WD1,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] RA,
    output logic [NUM_RD*DATA_WIDTH-1:0] RD,
    output logic                         READY
);

    // One extra bit so REG_COUNT == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH + 1)'(REG_COUNT);

    // x0 and anything past the implemented registers read as zero and swallow writes.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a != '0) && ({1'b0, a} < REG_LIMIT);
    endfunction

    logic                  clr_active;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  ready;

    regfile_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_clear_seq (
        .clk        (CLK),
        .rst_n      (RST_N),
        .clr_req    (CLR_REQ),
        .clr_active (clr_active),
        .clr_addr   (clr_addr),
        .ready      (ready)
    );

    assign READY = ready;

    // A clear request takes the cycle's writes with it, so they are neither
    // stored nor forwarded to readers.
    logic wr0_ok;
    logic wr1_ok;

    assign wr0_ok = ready && !CLR_REQ && WE0 && addr_ok(A0);
    assign wr1_ok = ready && !CLR_REQ && WE1 && addr_ok(A1);

    // Storage has no reset; it is zeroed only by the sweep. Port 1 is assigned
    // after port 0 so it wins when both target the same register.
    logic [DATA_WIDTH-1:0] mem [REG_COUNT];

    always_ff @(posedge CLK) begin
        if (clr_active) begin
            if (addr_ok(clr_addr)) begin
                mem[clr_addr] <= '0;
            end
        end else begin
            if (wr0_ok) begin
                mem[A0] <= WD0;
            end
            if (wr1_ok) begin
                mem[A1] <= WD1;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rdat;

        assign ra = RA[i*ADDR_WIDTH +: ADDR_WIDTH];

        // While sweeping the array is half-cleared, so every port reads zero
        // rather than exposing stale contents.
        always_comb begin
            rdat = '0;
            if (ready && addr_ok(ra)) begin
                rdat = mem[ra];
                if (BYPASS != 0) begin
                    if (wr0_ok && (A0 == ra)) begin
                        rdat = WD0;
                    end
                    if (wr1_ok && (A1 == ra)) begin
                        rdat = WD1;
                    end
                end
            end
        end

        assign RD[i*DATA_WIDTH +: DATA_WIDTH] = rdat;
    end

endmodule
